// File: rtl/aemb_pkg.sv
// Shared constants for the AEMB interrupt controller and later multi-source blocks.
package aemb_pkg;

  localparam logic [2:0] INTC_STAT = 3'd0;
  localparam logic [2:0] INTC_MASK = 3'd1;
  localparam logic [2:0] INTC_MODE = 3'd2;
  localparam logic [2:0] INTC_CLR  = 3'd3;
  localparam logic [2:0] INTC_VEC  = 3'd4;

  localparam int VEC_VALID_BIT = 31;
  localparam int VEC_W         = 5;

endpackage

// File: rtl/aemb_intc_prio.sv
// Lowest-index-wins priority encoder: reports whether any request is set and which.
module aemb_intc_prio
  import aemb_pkg::*;
#(
  parameter int NINT = 8
) (
  input  logic [NINT-1:0]  req,
  output logic             valid,
  output logic [VEC_W-1:0] idx
);

  // Scan from the top down so the lowest set index is the last assignment.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = NINT - 1; i >= 0; i--) begin
      if (req[i]) idx = VEC_W'(i);
    end
  end

endmodule

// File: rtl/aemb_intc.sv
// AEMB interrupt controller: synchronises sources, latches edge/level events,
// masks and priority-encodes them, and exposes config/ack over Wishbone classic.
module aemb_intc
  import aemb_pkg::*;
#(
  parameter int NINT = 8,
  parameter int SYNC = 2
) (
  input  logic            gclk,
  input  logic            grst,
  input  logic [NINT-1:0] int_i,
  input  logic            wb_stb_i,
  input  logic            wb_we_i,
  input  logic [2:0]      wb_adr_i,
  input  logic [31:0]     wb_dat_i,
  output logic [31:0]     wb_dat_o,
  output logic            wb_ack_o,
  output logic            sys_int_o
);

  // Bits above NINT-1 are held at zero so reads return 0 and writes are dropped.
  localparam logic [31:0] REG_BITS = 32'((64'd1 << NINT) - 64'd1);

  logic [NINT-1:0] syncQ [SYNC];
  logic [NINT-1:0] sNow;
  logic [NINT-1:0] sDly;
  logic [NINT-1:0] pending;
  logic [31:0]     maskReg;
  logic [31:0]     modeReg;

  logic            wbCyc;
  logic            wrEn;
  logic [NINT-1:0] clrBits;
  logic [NINT-1:0] riseBits;
  logic [NINT-1:0] pendingNext;
  logic [NINT-1:0] active;
  logic            vecValid;
  logic [VEC_W-1:0] vecIdx;
  logic [31:0]     vecWord;
  logic [31:0]     rdData;

  assign sNow = syncQ[SYNC-1];

  always_ff @(posedge gclk) begin
    if (grst) begin
      for (int k = 0; k < SYNC; k++) syncQ[k] <= '0;
      sDly <= '0;
    end else begin
      syncQ[0] <= int_i;
      for (int k = 1; k < SYNC; k++) syncQ[k] <= syncQ[k-1];
      sDly <= sNow;
    end
  end

  assign wbCyc = wb_stb_i & ~wb_ack_o;
  assign wrEn  = wbCyc & wb_we_i;

  assign clrBits  = (wrEn && wb_adr_i == INTC_CLR) ? wb_dat_i[NINT-1:0] : '0;
  assign riseBits = sNow & ~sDly;

  // Set beats clear: a new edge landing with a CLR write keeps the bit pending.
  assign pendingNext = (modeReg[NINT-1:0] & ((pending & ~clrBits) | riseBits))
                     | (~modeReg[NINT-1:0] & sNow);

  assign active = pending & maskReg[NINT-1:0];

  aemb_intc_prio #(.NINT(NINT)) uPrio (
    .req   (active),
    .valid (vecValid),
    .idx   (vecIdx)
  );

  always_comb begin
    vecWord                  = '0;
    vecWord[VEC_VALID_BIT]   = vecValid;
    vecWord[VEC_W-1:0]       = vecIdx;
  end

  always_comb begin
    rdData = '0;
    case (wb_adr_i)
      INTC_STAT: rdData = 32'(pending);
      INTC_MASK: rdData = maskReg;
      INTC_MODE: rdData = modeReg;
      INTC_VEC:  rdData = vecWord;
      default:   rdData = '0;
    endcase
  end

  always_ff @(posedge gclk) begin
    if (grst) begin
      pending   <= '0;
      maskReg   <= '0;
      modeReg   <= '0;
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= '0;
      sys_int_o <= 1'b0;
    end else begin
      pending   <= pendingNext;
      sys_int_o <= |active;
      wb_ack_o  <= wbCyc;
      wb_dat_o  <= wbCyc ? rdData : 32'd0;
      if (wrEn && wb_adr_i == INTC_MASK) maskReg <= wb_dat_i & REG_BITS;
      if (wrEn && wb_adr_i == INTC_MODE) modeReg <= wb_dat_i & REG_BITS;
    end
  end

endmodule

// File: tb/tb_aemb_intc.sv
// Directed bench for aemb_intc: stimulus queues expected read data, a monitor checks acks.
module tb_aemb_intc;
  import aemb_pkg::*;

  localparam int NINT = 8;
  localparam int SYNC = 2;

  logic            gclk = 1'b0;
  logic            grst = 1'b1;
  logic [NINT-1:0] int_i = '0;
  logic            wb_stb_i = 1'b0;
  logic            wb_we_i = 1'b0;
  logic [2:0]      wb_adr_i = '0;
  logic [31:0]     wb_dat_i = '0;
  logic [31:0]     wb_dat_o;
  logic            wb_ack_o;
  logic            sys_int_o;

  aemb_intc #(.NINT(NINT), .SYNC(SYNC)) dut (
    .gclk      (gclk),
    .grst      (grst),
    .int_i     (int_i),
    .wb_stb_i  (wb_stb_i),
    .wb_we_i   (wb_we_i),
    .wb_adr_i  (wb_adr_i),
    .wb_dat_i  (wb_dat_i),
    .wb_dat_o  (wb_dat_o),
    .wb_ack_o  (wb_ack_o),
    .sys_int_o (sys_int_o)
  );

  always #5 gclk = ~gclk;

  typedef struct {
    logic        isRd;
    logic [31:0] exp;
    string       name;
  } sbEntry_t;

  sbEntry_t sbQ[$];
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every ack consumes one queued access; reads compare data.
  always @(negedge gclk) begin
    sbEntry_t e;
    if (!grst && wb_ack_o === 1'b1) begin
      if (sbQ.size() == 0) begin
        check("spuriousAck", 32'(wb_ack_o), 32'd0);
      end else begin
        e = sbQ.pop_front();
        if (e.isRd) check(e.name, wb_dat_o, e.exp);
      end
    end
  end

  task automatic wbXfer(input logic w, input logic [2:0] a, input logic [31:0] d,
                        input logic [31:0] exp, input string name);
    sbEntry_t e;
    @(negedge gclk);
    e.isRd = !w;
    e.exp  = exp;
    e.name = name;
    sbQ.push_back(e);
    wb_stb_i = 1'b1;
    wb_we_i  = w;
    wb_adr_i = a;
    wb_dat_i = d;
    @(posedge gclk);
    #1 check({name, "_ack"}, 32'(wb_ack_o), 32'd1);
    @(negedge gclk);
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic wbRd(input logic [2:0] a, input logic [31:0] exp, input string name);
    wbXfer(1'b0, a, 32'd0, exp, name);
  endtask

  task automatic wbWr(input logic [2:0] a, input logic [31:0] d, input string name);
    wbXfer(1'b1, a, d, 32'd0, name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge gclk);
    grst = 1'b0;

    // Reset state: all addresses read zero, no request.
    check("rstIrq", 32'(sys_int_o), 32'd0);
    for (int i = 0; i < 8; i++) wbRd(3'(i), 32'h0, $sformatf("rstRd%0d", i));

    // Edge mode, single source, latency and clear.
    wbWr(INTC_MODE, 32'hFF, "wrMode");
    wbWr(INTC_MASK, 32'h04, "wrMask");
    @(negedge gclk); int_i[2] = 1'b1;
    @(negedge gclk); int_i[2] = 1'b0;
    @(posedge gclk);
    @(posedge gclk);
    @(negedge gclk); check("irqEarly", 32'(sys_int_o), 32'd0);
    @(posedge gclk);
    @(negedge gclk); check("irqLat", 32'(sys_int_o), 32'd1);
    wbRd(INTC_STAT, 32'h04, "stat2");
    wbRd(INTC_VEC, 32'h8000_0002, "vec2");
    wbWr(INTC_CLR, 32'h04, "clr2");
    check("irqAtClr", 32'(sys_int_o), 32'd1);
    @(negedge gclk); check("irqCleared", 32'(sys_int_o), 32'd0);
    wbRd(INTC_STAT, 32'h00, "stat2Clr");

    // Masked events and priority.
    wbWr(INTC_MASK, 32'h00, "mask0");
    @(negedge gclk); int_i = 8'h22;
    @(negedge gclk); int_i = 8'h00;
    repeat (4) @(negedge gclk);
    check("irqMasked", 32'(sys_int_o), 32'd0);
    wbRd(INTC_STAT, 32'h22, "stat22");
    wbWr(INTC_MASK, 32'h20, "mask20");
    wbRd(INTC_VEC, 32'h8000_0005, "vec5");
    check("irqMask20", 32'(sys_int_o), 32'd1);
    wbWr(INTC_MASK, 32'h22, "mask22");
    wbRd(INTC_VEC, 32'h8000_0001, "vec1");
    wbWr(INTC_CLR, 32'h22, "clr22");
    wbRd(INTC_STAT, 32'h00, "stat22Clr");

    // Level mode: CLR ignored, follows source.
    wbWr(INTC_MODE, 32'h00, "modeLvl");
    wbWr(INTC_MASK, 32'h01, "mask1");
    @(negedge gclk); int_i[0] = 1'b1;
    repeat (5) @(negedge gclk);
    wbRd(INTC_STAT, 32'h01, "lvlStat");
    check("lvlIrq", 32'(sys_int_o), 32'd1);
    wbWr(INTC_CLR, 32'h01, "lvlClr");
    wbRd(INTC_STAT, 32'h01, "lvlStatClr");
    @(negedge gclk); int_i[0] = 1'b0;
    repeat (3) @(posedge gclk);
    @(negedge gclk); check("lvlHold", 32'(sys_int_o), 32'd1);
    @(posedge gclk);
    @(negedge gclk); check("lvlDrop", 32'(sys_int_o), 32'd0);
    wbRd(INTC_STAT, 32'h00, "lvlStatDrop");

    // Edge detection coinciding with the committing CLR write: set wins.
    wbWr(INTC_MODE, 32'hFF, "modeEdge");
    wbWr(INTC_MASK, 32'h08, "mask8");
    @(negedge gclk); int_i[3] = 1'b1;
    @(negedge gclk);
    wbWr(INTC_CLR, 32'h08, "clrRace");
    wbRd(INTC_STAT, 32'h08, "statRace");
    check("irqRace", 32'(sys_int_o), 32'd1);
    int_i[3] = 1'b0;

    // Reset during a write that has not been acked yet.
    @(negedge gclk);
    wb_stb_i = 1'b1;
    wb_we_i  = 1'b1;
    wb_adr_i = INTC_MASK;
    wb_dat_i = 32'hFF;
    grst     = 1'b1;
    @(posedge gclk);
    #1 check("rstMidAck", 32'(wb_ack_o), 32'd0);
    @(negedge gclk);
    grst     = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    wbRd(INTC_MASK, 32'h00, "maskAfterRst");
    wbRd(INTC_STAT, 32'h00, "statAfterRst");
    check("irqAfterRst", 32'(sys_int_o), 32'd0);

    repeat (3) @(negedge gclk);
    check("sbEmpty", 32'(sbQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aemb_intc.md
Name: aemb_intc

Overview:
- Interrupt controller for the AEMB core.
- Collects NINT external interrupt sources and latches edge- or level-mode events into a pending register.
- Masks the pending events, priority-encodes them into a vector, and drives the single `sys_int_i` line of the system control unit.
- Software configures and acknowledges it through a Wishbone-classic slave port on the data bus.

Parameters:
- NINT, 8, number of interrupt sources (1..32).
- SYNC, 2, synchroniser flop stages per source (min 2).

Ports:
- gclk  in  1  clock
- grst  in  1  reset, synchronous, active-high
- int_i  in  NINT  raw asynchronous interrupt sources
- wb_stb_i  in  1  slave strobe (cycle qualifier)
- wb_we_i  in  1  write enable
- wb_adr_i  in  3  word address of register
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data, valid while wb_ack_o high
- wb_ack_o  out  1  access acknowledge
- sys_int_o  out  1  interrupt request to core (`sys_int_i` of system control)

Behaviour:
- Reset values: every register, synchroniser flop, wb_ack_o, wb_dat_o and sys_int_o are 0.
- Synchronisation: each int_i bit passes through a SYNC-stage flop chain, giving s[i]. A further flop holds s_d[i] for edge detection.
- Register map, word address on wb_adr_i; bits above NINT-1 read 0 and ignore writes:
  - 0 STAT: RO, pending[NINT-1:0].
  - 1 MASK: RW, 1 = enabled.
  - 2 MODE: RW, 1 = rising-edge, 0 = level.
  - 3 CLR: WO, write-1-to-clear pending (edge-mode bits only); reads 0.
  - 4 VEC: RO. bit31 = valid; bits[4:0] = lowest index i with pending[i] & mask[i]; all 0 when nothing enabled is pending.
  - 5..7: read 0, writes ignored.
- Pending update, every cycle, per bit i:
  - Edge mode: pending[i] <= (pending[i] & ~clr[i]) | (s[i] & ~s_d[i]). A set and a clear in the same cycle leave the bit set.
  - Level mode: pending[i] <= s[i]. CLR has no effect.
  - Writing MODE takes effect the next cycle. It does not clear pending; the bit simply starts following the new rule.
- sys_int_o is registered: sys_int_o <= |(pending & mask). This gives 1 cycle from pending set to request.
  - Total latency from int_i edge to sys_int_o = SYNC + 2 cycles.
  - It stays high until software clears, masks, or the level source drops.
- Wishbone handshake:
  - wb_ack_o <= wb_stb_i & ~wb_ack_o, i.e. one cycle after stb, exactly one ack per access.
  - A held stb produces an ack every other cycle. The core's stall logic drops stb after ack.
  - A write commits on the cycle ack is asserted (stb & ~ack). Read data is registered alongside ack.
  - The VEC read value is sampled at the same cycle as the register read.
- Reset mid-access: ack is dropped, no write commits, and all pending bits are lost.
- NINT = 1: VEC index is always 0; valid = pending[0] & mask[0].

Decomposition:
- Shared package aemb_pkg holds:
  - register address constants INTC_STAT/MASK/MODE/CLR/VEC (0..4);
  - the VEC valid bit position (31);
  - the vector field width (5).
- Sub-module aemb_intc_prio holds the parameterised lowest-index priority encoder (combinational, NINT in → valid + 5-bit index). It is reused by later multi-source blocks.
- Synchroniser chain stays inline.

Test Plan:
- Reset, then read all 8 addresses → every read returns 0x00000000; each access acks exactly 1 cycle after stb; sys_int_o = 0.
- MODE=0xFF, MASK=0x04; pulse int_i[2] for 1 cycle → STAT=0x04 and sys_int_o high exactly SYNC+2 = 4 cycles after the edge; VEC = 0x80000002; write CLR=0x04 → sys_int_o low 2 cycles later, STAT=0.
- MODE=0xFF, MASK=0x00; edges on bits 5 and 1 → STAT=0x22, sys_int_o stays 0; then MASK=0x20 → VEC=0x80000005, sys_int_o=1; MASK=0x22 → VEC=0x80000001.
- MODE=0x00 (level), MASK=0x01; hold int_i[0] high → STAT=0x01 persists through CLR=0x01 write; drop int_i[0] → STAT=0 and sys_int_o=0 after SYNC+2 cycles.
- Edge mode, bit 3: time a new rising edge so its detection coincides with the committing CLR=0x08 write → STAT bit 3 remains 1 afterwards.
- Assert grst during a write of MASK=0xFF with ack not yet given → MASK reads 0 after reset; no spurious ack in the reset cycle.
